// File: rtl/sdram_chip_model.sv
// Cycle-accurate single-chip SDR SDRAM responder (4 banks, x16) that flags protocol violations.
// Optional refresh-interval watchdog on err[4]: define SDRAM_MODEL_REFI_CHECK_EN.
module sdram_chip_model #(
    parameter int unsigned ROW_BITS    = 6,
    parameter int unsigned COL_BITS    = 8,
    parameter int unsigned RCD_CYCLES  = 2,
    parameter int unsigned REFI_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sdram_ncs,
    input  logic        sdram_nras,
    input  logic        sdram_ncas,
    input  logic        sdram_nwe,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_a,
    input  logic        sdram_dqml,
    input  logic        sdram_dqmh,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic [4:0]  err,
    output logic [15:0] refresh_cnt
);
    localparam int unsigned AW    = 2 + ROW_BITS + COL_BITS;
    localparam int unsigned RCD_W = $clog2(RCD_CYCLES + 1);

    typedef struct packed {
        logic                v;
        logic [1:0]          ba;
        logic [ROW_BITS-1:0] row;
        logic [COL_BITS-1:0] col;
    } beat_t;

    logic [15:0]         mem [2**AW];
    logic [3:0]          bank_open;
    logic [ROW_BITS-1:0] bank_row [4];
    logic [RCD_W-1:0]    rcd_cnt [4];
    logic [3:0]          ap_pend;
    logic [2:0]          ap_cnt [4];
    logic                mode_valid, mode_cl3, mode_bl2, mode_wsingle;
    beat_t               pipe [4];
    logic                wb_pend;
    logic [AW-1:0]       wb_addr;

    logic is_lmr, is_ref, is_pre, is_act, is_wr, is_rd, is_bt;
    logic lmr_ok, do_read, do_write, conflict;
    logic [4:0] err_set;
    logic          mem_we;
    logic [1:0]    mem_be;
    logic [AW-1:0] mem_addr, rd_addr;
    logic [15:0]   mem_data;
    beat_t         rd_b0, rd_b1;
    logic unused_a;

    assign unused_a = ^{sdram_a, 32'(REFI_CYCLES)};
    assign rd_addr  = {pipe[0].ba, pipe[0].row, pipe[0].col};

`ifdef SDRAM_MODEL_REFI_CHECK_EN
    localparam int unsigned REFI_W = $clog2(REFI_CYCLES + 1);
    logic [REFI_W-1:0] refi_cnt;

    // Refresh-interval watchdog: saturates at REFI_CYCLES
    always_ff @(posedge clk) begin
        if (reset || is_ref) begin
            refi_cnt <= '0;
        end else if (refi_cnt != REFI_W'(REFI_CYCLES)) begin
            refi_cnt <= refi_cnt + REFI_W'(1);
        end
    end
`endif

    // Command decode, violation detection and memory write port
    always_comb begin
        is_lmr = 1'b0; is_ref = 1'b0; is_pre = 1'b0; is_act = 1'b0;
        is_wr  = 1'b0; is_rd  = 1'b0; is_bt  = 1'b0;
        if (!sdram_ncs) begin
            case ({sdram_nras, sdram_ncas, sdram_nwe})
                3'b000:  is_lmr = 1'b1;
                3'b001:  is_ref = 1'b1;
                3'b010:  is_pre = 1'b1;
                3'b011:  is_act = 1'b1;
                3'b100:  is_wr  = 1'b1;
                3'b101:  is_rd  = 1'b1;
                3'b110:  is_bt  = 1'b1;
                default: ;
            endcase
        end
        lmr_ok   = (sdram_a[2:0] <= 3'd1) && ((sdram_a[6:4] == 3'd2) || (sdram_a[6:4] == 3'd3));
        do_read  = is_rd && mode_valid && bank_open[sdram_ba];
        do_write = is_wr && mode_valid && bank_open[sdram_ba];
        conflict = do_write && pipe[0].v;

        err_set    = '0;
        err_set[0] = (is_act && bank_open[sdram_ba]) || ((is_rd || is_wr) && !bank_open[sdram_ba])
                   || (is_ref && (|bank_open));
        err_set[1] = (do_read || do_write) && (rcd_cnt[sdram_ba] < RCD_W'(RCD_CYCLES));
        err_set[2] = (is_lmr && !lmr_ok) || ((is_rd || is_wr) && !mode_valid);
        err_set[3] = conflict;
`ifdef SDRAM_MODEL_REFI_CHECK_EN
        err_set[4] = !is_ref && (refi_cnt == REFI_W'(REFI_CYCLES - 1));
`endif

        // A new WRITE or READ pre-empts the second beat of a burst write
        mem_we   = 1'b0;
        mem_be   = 2'b00;
        mem_addr = wb_addr;
        mem_data = dq_in;
        if (do_write) begin
            mem_we   = 1'b1;
            mem_be   = {~sdram_dqmh, ~sdram_dqml};
            mem_addr = {sdram_ba, bank_row[sdram_ba], sdram_a[COL_BITS-1:0]};
        end else if (wb_pend && !do_read) begin
            mem_we   = 1'b1;
            mem_be   = {~sdram_dqmh, ~sdram_dqml};
        end

        rd_b0     = '{v: 1'b1, ba: sdram_ba, row: bank_row[sdram_ba], col: sdram_a[COL_BITS-1:0]};
        rd_b1     = rd_b0;
        rd_b1.col = {rd_b0.col[COL_BITS-1:1], ~rd_b0.col[0]};
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (mem_be[1]) mem[mem_addr][15:8] <= mem_data[15:8];
            if (mem_be[0]) mem[mem_addr][7:0]  <= mem_data[7:0];
        end
    end

    // Bank state, mode register, read pipeline and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_open    <= '0;
            ap_pend      <= '0;
            mode_valid   <= 1'b0;
            mode_cl3     <= 1'b0;
            mode_bl2     <= 1'b0;
            mode_wsingle <= 1'b0;
            wb_pend      <= 1'b0;
            wb_addr      <= '0;
            dq_out       <= '0;
            dq_oe        <= 1'b0;
            err          <= '0;
            refresh_cnt  <= '0;
            for (int b = 0; b < 4; b++) begin
                bank_row[b] <= '0;
                rcd_cnt[b]  <= '0;
                ap_cnt[b]   <= '0;
                pipe[b]     <= '0;
            end
        end else begin
            err <= err | err_set;
            for (int b = 0; b < 4; b++) begin
                if (rcd_cnt[b] < RCD_W'(RCD_CYCLES)) rcd_cnt[b] <= rcd_cnt[b] + RCD_W'(1);
                if (ap_pend[b]) begin
                    if (ap_cnt[b] == 3'd1) begin
                        bank_open[b] <= 1'b0;
                        ap_pend[b]   <= 1'b0;
                    end else begin
                        ap_cnt[b] <= ap_cnt[b] - 3'd1;
                    end
                end
            end

            dq_oe  <= pipe[0].v && !conflict;
            dq_out <= (pipe[0].v && !conflict) ? mem[rd_addr] : 16'h0000;
            pipe[0] <= pipe[1];
            pipe[1] <= pipe[2];
            pipe[2] <= pipe[3];
            pipe[3] <= '0;

            // WRITE drops every pending beat; READ/BURST_TERMINATE drop beats from their own CL on
            if (do_write) begin
                for (int j = 0; j < 4; j++) pipe[j] <= '0;
            end else if (do_read || is_bt) begin
                pipe[3] <= '0;
                pipe[2] <= '0;
                if (!mode_cl3) pipe[1] <= '0;
            end
            if (do_read) begin
                if (mode_cl3) begin
                    pipe[2] <= rd_b0;
                    if (mode_bl2) pipe[3] <= rd_b1;
                end else begin
                    pipe[1] <= rd_b0;
                    if (mode_bl2) pipe[2] <= rd_b1;
                end
            end

            wb_pend <= do_write && mode_bl2 && !mode_wsingle;
            wb_addr <= {sdram_ba, bank_row[sdram_ba], rd_b1.col};

            if (is_lmr && lmr_ok) begin
                mode_valid   <= 1'b1;
                mode_bl2     <= sdram_a[0];
                mode_cl3     <= sdram_a[4];
                mode_wsingle <= sdram_a[9];
            end
            if (is_act) begin
                bank_open[sdram_ba] <= 1'b1;
                bank_row[sdram_ba]  <= sdram_a[ROW_BITS-1:0];
                rcd_cnt[sdram_ba]   <= RCD_W'(1);
                ap_pend[sdram_ba]   <= 1'b0;
            end
            // Auto-precharge closes the bank on the edge of the last beat
            if (do_read && sdram_a[10]) begin
                ap_pend[sdram_ba] <= 1'b1;
                ap_cnt[sdram_ba]  <= 3'd2 + 3'(mode_cl3) + 3'(mode_bl2);
            end
            if (do_write && sdram_a[10]) begin
                if (mode_bl2 && !mode_wsingle) begin
                    ap_pend[sdram_ba] <= 1'b1;
                    ap_cnt[sdram_ba]  <= 3'd1;
                end else begin
                    bank_open[sdram_ba] <= 1'b0;
                end
            end
            if (is_pre) begin
                if (sdram_a[10]) begin
                    bank_open <= '0;
                    ap_pend   <= '0;
                end else begin
                    bank_open[sdram_ba] <= 1'b0;
                    ap_pend[sdram_ba]   <= 1'b0;
                end
            end
            if (is_ref) refresh_cnt <= refresh_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_sdram_chip_model.sv
// Self-checking bench for sdram_chip_model: scoreboard of expected read beats keyed by clock edge.
module tb_sdram_chip_model;
    logic        clk = 1'b0;
    logic        reset;
    logic        sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_a;
    logic        sdram_dqml, sdram_dqmh;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [4:0]  err;
    logic [15:0] refresh_cnt;

    always #5 clk = ~clk;

    sdram_chip_model #(.REFI_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .sdram_ncs(sdram_ncs), .sdram_nras(sdram_nras),
        .sdram_ncas(sdram_ncas), .sdram_nwe(sdram_nwe), .sdram_ba(sdram_ba), .sdram_a(sdram_a),
        .sdram_dqml(sdram_dqml), .sdram_dqmh(sdram_dqmh), .dq_in(dq_in), .dq_out(dq_out),
        .dq_oe(dq_oe), .err(err), .refresh_cnt(refresh_cnt)
    );

`ifdef SDRAM_MODEL_REFI_CHECK_EN
    localparam logic [4:0] ERR_MASK = 5'h0f;
`else
    localparam logic [4:0] ERR_MASK = 5'h1f;
`endif
    localparam logic [2:0] C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_BT  = 3'b110;

    typedef struct { int unsigned cyc; logic [15:0] data; } exp_t;
    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    int unsigned cur_cl = 2;
    logic        cur_bl2 = 1'b0;

    // Compare the bus against the scoreboard once per cycle
    task automatic check_bus();
        exp_t e;
        if (dq_oe) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL bus_unexpected cyc=%0d got=%h required=idle", cyc, dq_out);
            end else begin
                e = sbq.pop_front();
                if (e.cyc != cyc || dq_out !== e.data) begin
                    bad++;
                    $display("FAIL bus_beat cyc=%0d got=%h required=%h@%0d", cyc, dq_out, e.data, e.cyc);
                end
            end
        end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
            total++;
            bad++;
            e = sbq.pop_front();
            $display("FAIL bus_missing cyc=%0d got=idle required=%h@%0d", cyc, e.data, e.cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_bus();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [15:0] d, input logic mh, input logic ml);
        {sdram_nras, sdram_ncas, sdram_nwe} = c;
        sdram_ba = ba; sdram_a = a; dq_in = d; sdram_dqmh = mh; sdram_dqml = ml;
        step();
        {sdram_nras, sdram_ncas, sdram_nwe} = 3'b111;
        sdram_dqmh = 1'b0; sdram_dqml = 1'b0;
    endtask

    task automatic cancel_from(input int unsigned from);
        exp_t keep[$];
        foreach (sbq[i]) if (sbq[i].cyc < from) keep.push_back(sbq[i]);
        sbq = keep;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        sbq.delete();
    endtask

    task automatic load_mode(input logic [12:0] a);
        cur_cl  = 32'(a[6:4]);
        cur_bl2 = a[0];
        issue(C_LMR, 2'd0, a, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic read_exp(input logic [1:0] ba, input logic [7:0] col, input logic ap,
                            input logic [15:0] e0, input logic [15:0] e1);
        logic [12:0] a;
        int unsigned edge_n;
        edge_n = cyc + 1;
        a = '0; a[7:0] = col; a[10] = ap;
        cancel_from(edge_n + cur_cl);
        sbq.push_back('{cyc: edge_n + cur_cl, data: e0});
        if (cur_bl2) sbq.push_back('{cyc: edge_n + cur_cl + 1, data: e1});
        issue(C_RD, ba, a, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic write_w(input logic [1:0] ba, input logic [7:0] col, input logic ap,
                           input logic [15:0] d, input logic mh, input logic ml);
        logic [12:0] a;
        a = '0; a[7:0] = col; a[10] = ap;
        cancel_from(cyc + 1);
        issue(C_WR, ba, a, d, mh, ml);
    endtask

    task automatic check_err(input string name, input logic [4:0] req);
        total++;
        if ((err & ERR_MASK) !== req) begin
            bad++;
            $display("FAIL %s got=%b required=%b", name, err, req);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total += 4;
        if (dq_oe !== 1'b0)        begin bad++; $display("FAIL reset_oe got=%b required=0", dq_oe); end
        if (dq_out !== 16'h0)      begin bad++; $display("FAIL reset_dq got=%h required=0000", dq_out); end
        if (err !== 5'b0)          begin bad++; $display("FAIL reset_err got=%b required=00000", err); end
        if (refresh_cnt !== 16'h0) begin bad++; $display("FAIL reset_ref got=%0d required=0", refresh_cnt); end
    endtask

    task automatic test_bringup();
        issue(C_PRE, 2'd0, 13'h400, 16'h0, 1'b0, 1'b0);
        load_mode(13'h220);
        issue(C_ACT, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0);
        idle(2);
        write_w(2'd1, 8'h12, 1'b0, 16'hA55A, 1'b0, 1'b0);
        read_exp(2'd1, 8'h12, 1'b0, 16'hA55A, 16'h0);
        // Deselected READ must be ignored
        sdram_ncs = 1'b1;
        issue(C_RD, 2'd1, 13'h12, 16'h0, 1'b0, 1'b0);
        sdram_ncs = 1'b0;
        idle(4);
        check_err("bringup_err", 5'b00000);
    endtask

    task automatic test_bl2_cl3();
        load_mode(13'h231);
        write_w(2'd1, 8'h03, 1'b0, 16'h1111, 1'b0, 1'b0);
        write_w(2'd1, 8'h02, 1'b0, 16'h2222, 1'b0, 1'b0);
        read_exp(2'd1, 8'h03, 1'b0, 16'h1111, 16'h2222);
        idle(6);
        check_err("bl2_cl3_err", 5'b00000);
    endtask

    task automatic test_byte_mask();
        load_mode(13'h220);
        write_w(2'd1, 8'h20, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        write_w(2'd1, 8'h20, 1'b0, 16'h1234, 1'b1, 1'b0);
        read_exp(2'd1, 8'h20, 1'b0, 16'hFF34, 16'h0);
        idle(3);
        write_w(2'd1, 8'h20, 1'b0, 16'hABCD, 1'b0, 1'b1);
        read_exp(2'd1, 8'h20, 1'b0, 16'hAB34, 16'h0);
        idle(4);
        check_err("byte_mask_err", 5'b00000);
    endtask

    task automatic test_protocol();
        do_reset();
        load_mode(13'h220);
        issue(C_RD, 2'd2, 13'h0, 16'h0, 1'b0, 1'b0);
        issue(C_ACT, 2'd0, 13'd1, 16'h0, 1'b0, 1'b0);
        idle(2);
        write_w(2'd0, 8'h05, 1'b0, 16'hBEEF, 1'b0, 1'b0);
        issue(C_PRE, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
        issue(C_ACT, 2'd0, 13'd1, 16'h0, 1'b0, 1'b0);
        read_exp(2'd0, 8'h05, 1'b0, 16'hBEEF, 16'h0);
        issue(C_REF, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
        idle(4);
        check_err("protocol_err", 5'b00011);
        total++;
        if (refresh_cnt !== 16'd1) begin bad++; $display("FAIL protocol_ref got=%0d required=1", refresh_cnt); end
        issue(C_PRE, 2'd0, 13'h400, 16'h0, 1'b0, 1'b0);
        issue(C_REF, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
        total++;
        if (refresh_cnt !== 16'd2) begin bad++; $display("FAIL protocol_ref2 got=%0d required=2", refresh_cnt); end
    endtask

    task automatic test_mode_errors();
        do_reset();
        issue(C_ACT, 2'd0, 13'd1, 16'h0, 1'b0, 1'b0);
        idle(2);
        issue(C_RD, 2'd0, 13'h05, 16'h0, 1'b0, 1'b0);
        idle(4);
        check_err("no_mode_err", 5'b00100);
        load_mode(13'h220);
        issue(C_LMR, 2'd0, 13'h233, 16'h0, 1'b0, 1'b0);
        read_exp(2'd0, 8'h05, 1'b0, 16'hBEEF, 16'h0);
        idle(4);
        check_err("bad_mode_err", 5'b00100);
    endtask

    task automatic test_interrupt();
        int unsigned bt_edge;
        do_reset();
        load_mode(13'h221);
        issue(C_ACT, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0);
        idle(2);
        read_exp(2'd1, 8'h03, 1'b0, 16'h1111, 16'h2222);
        bt_edge = cyc + 1;
        cancel_from(bt_edge + cur_cl);
        issue(C_BT, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
        idle(4);
        check_err("bterm_err", 5'b00000);
        read_exp(2'd1, 8'h03, 1'b0, 16'h1111, 16'h2222);
        step();
        write_w(2'd1, 8'h40, 1'b0, 16'h7777, 1'b0, 1'b0);
        idle(4);
        check_err("conflict_err", 5'b01000);
        load_mode(13'h220);
        read_exp(2'd1, 8'h40, 1'b0, 16'h7777, 16'h0);
        idle(4);
    endtask

    task automatic test_auto_precharge();
        do_reset();
        load_mode(13'h220);
        issue(C_ACT, 2'd2, 13'd7, 16'h0, 1'b0, 1'b0);
        idle(2);
        write_w(2'd2, 8'h01, 1'b1, 16'h5A5A, 1'b0, 1'b0);
        issue(C_RD, 2'd2, 13'h01, 16'h0, 1'b0, 1'b0);
        idle(4);
        check_err("ap_write_err", 5'b00001);
        do_reset();
        load_mode(13'h220);
        issue(C_ACT, 2'd2, 13'd7, 16'h0, 1'b0, 1'b0);
        idle(2);
        read_exp(2'd2, 8'h01, 1'b1, 16'h5A5A, 16'h0);
        issue(C_ACT, 2'd2, 13'd7, 16'h0, 1'b0, 1'b0);
        idle(4);
        check_err("ap_read_err", 5'b00001);
    endtask

    task automatic test_reset_midread();
        do_reset();
        load_mode(13'h220);
        issue(C_ACT, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0);
        idle(2);
        issue(C_RD, 2'd1, 13'h03, 16'h0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        total++;
        if (dq_oe !== 1'b0) begin bad++; $display("FAIL midread_oe got=%b required=0", dq_oe); end
        reset = 1'b0;
        idle(3);
        total++;
        if (dq_oe !== 1'b0) begin bad++; $display("FAIL midread_flush got=%b required=0", dq_oe); end
        check_err("midread_err", 5'b00000);
    endtask

`ifdef SDRAM_MODEL_REFI_CHECK_EN
    task automatic test_refi();
        do_reset();
        idle(15);
        total++;
        if (err[4] !== 1'b0) begin bad++; $display("FAIL refi_early got=%b required=0", err[4]); end
        step();
        total++;
        if (err[4] !== 1'b1) begin bad++; $display("FAIL refi_late got=%b required=1", err[4]); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        sdram_ncs = 1'b0;
        {sdram_nras, sdram_ncas, sdram_nwe} = 3'b111;
        sdram_ba = '0; sdram_a = '0; sdram_dqml = 1'b0; sdram_dqmh = 1'b0; dq_in = '0;
        test_reset();
        test_bringup();
        test_bl2_cl3();
        test_byte_mask();
        test_protocol();
        test_mode_errors();
        test_interrupt();
        test_auto_precharge();
        test_reset_midread();
`ifdef SDRAM_MODEL_REFI_CHECK_EN
        test_refi();
`endif
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_left got=%0d required=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
